writeback_arbiter: RTL and testbench

Serialises register write-back from the four execution-stage result sources (misc, alu, mem, fpu) onto a single register-file write port. Each source gets a small FIFO so simultaneous results are never lost. A round-robin grant drains the FIFOs, and a registered stall back-pressures issue. A hazard query port reports whether a register still has a write-back in flight. The block sits between the execution units and the register manager.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/writeback_arbiter.sv | 132 +++++++++++++
 tb/tb_writeback_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register write-back arbiter.
// A request carries the destination register, the result and the file select.
package wb_pkg;

    localparam int N_SRC    = 4;
    localparam int SRC_MISC = 0;
    localparam int SRC_ALU  = 1;
    localparam int SRC_MEM  = 2;
    localparam int SRC_FPU  = 3;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        float;
    } wb_req_t;

    // Integer r0 is hardwired zero, so writes to it carry no architectural effect.
    function automatic logic req_writes(input wb_req_t r);
        return !(r.addr == 5'd0 && !r.float);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO with an associative (addr, float) match across live entries.
// A push while full is ignored unless a pop frees the slot in the same cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  wb_req_t                  din,
    input  logic [4:0]               query_addr,
    input  logic                     query_float,
    output wb_req_t                  head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     match
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_req_t        mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           wr_en;

    assign full  = (count == CW'(DEPTH));
    assign wr_en = push && (!full || pop);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [AW-1:0] offs;
        match = 1'b0;
        offs  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = AW'(i) - rd_ptr;
            if ({1'b0, offs} < count && mem[i].addr == query_addr && mem[i].float == query_float)
                match = 1'b1;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin serialiser of four execution-unit results onto one register-file write port,
// with per-source FIFOs, registered back-pressure and a pending-write hazard query.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req_enable,
    input  logic [19:0]  req_addr,
    input  logic [127:0] req_data,
    input  logic [3:0]   req_float,
    output logic         wb_enable,
    output logic [4:0]   wb_addr,
    output logic [31:0]  wb_data,
    output logic         wb_float,
    output logic         stall,
    output logic         overflow,
    input  logic [4:0]   query_addr,
    input  logic         query_float,
    output logic         query_hit
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_req_t            req       [N_SRC];
    wb_req_t            head      [N_SRC];
    wb_req_t            cand      [N_SRC];
    logic [CW-1:0]      count     [N_SRC];
    logic [N_SRC-1:0]   req_valid;
    logic [N_SRC-1:0]   empty;
    logic [N_SRC-1:0]   full;
    logic [N_SRC-1:0]   cand_valid;
    logic [N_SRC-1:0]   push;
    logic [N_SRC-1:0]   pop;
    logic [N_SRC-1:0]   drop;
    logic [N_SRC-1:0]   fifo_match;
    logic [1:0]         last_grant;
    logic [1:0]         grant;
    logic               grant_valid;
    logic               stall_next;

    // A source with queued results must drain them before its live request may bypass.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            req[i].addr   = req_addr[5*i +: 5];
            req[i].data   = req_data[32*i +: 32];
            req[i].float  = req_float[i];
            req_valid[i]  = req_enable[i] && req_writes(req[i]);
            empty[i]      = (count[i] == '0);
            cand[i]       = empty[i] ? req[i] : head[i];
            cand_valid[i] = !empty[i] || req_valid[i];
        end
    end

    always_comb begin
        logic [1:0] idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = last_grant + 2'(k);
            if (!grant_valid && cand_valid[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        logic [CW-1:0] cnt_next;
        stall_next = 1'b0;
        cnt_next   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pop[i]   = grant_valid && grant == 2'(i) && !empty[i];
            push[i]  = req_valid[i] && !(grant_valid && grant == 2'(i) && empty[i]);
            drop[i]  = push[i] && full[i] && !pop[i];
            cnt_next = count[i] + CW'(push[i] && !drop[i]) - CW'(pop[i]);
            if (cnt_next >= CW'(DEPTH - 1)) stall_next = 1'b1;
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_fifo
        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push        (push[g]),
            .pop         (pop[g]),
            .din         (req[g]),
            .query_addr  (query_addr),
            .query_float (query_float),
            .head        (head[g]),
            .count       (count[g]),
            .full        (full[g]),
            .match       (fifo_match[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_enable  <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_float   <= 1'b0;
            stall      <= 1'b0;
            overflow   <= 1'b0;
            last_grant <= 2'd3;
        end else begin
            wb_enable <= grant_valid;
            if (grant_valid) begin
                wb_addr    <= cand[grant].addr;
                wb_data    <= cand[grant].data;
                wb_float   <= cand[grant].float;
                last_grant <= grant;
            end
            stall <= stall_next;
            if (|drop) overflow <= 1'b1;
        end
    end

    always_comb begin
        query_hit = |fifo_match;
        for (int i = 0; i < N_SRC; i++) begin
            if (req_valid[i] && req[i].addr == query_addr && req[i].float == query_float)
                query_hit = 1'b1;
        end
        if (wb_enable && wb_addr == query_addr && wb_float == query_float)
            query_hit = 1'b1;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed bursts push expected write-backs,
// a negedge monitor pops and compares every wb_enable pulse in order.
module tb_writeback_arbiter;
    import wb_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req_enable = '0;
    logic [19:0]  req_addr = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_float = '0;
    logic         wb_enable;
    logic [4:0]   wb_addr;
    logic [31:0]  wb_data;
    logic         wb_float;
    logic         stall;
    logic         overflow;
    logic [4:0]   query_addr = '0;
    logic         query_float = 1'b0;
    logic         query_hit;

    wb_req_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    writeback_arbiter #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_enable  (req_enable),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_float   (req_float),
        .wb_enable   (wb_enable),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_float    (wb_float),
        .stall       (stall),
        .overflow    (overflow),
        .query_addr  (query_addr),
        .query_float (query_float),
        .query_hit   (query_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int s, input logic [4:0] a, input logic [31:0] d, input logic f);
        req_enable[s]       = 1'b1;
        req_addr[5*s +: 5]  = a;
        req_data[32*s +: 32] = d;
        req_float[s]        = f;
    endtask

    task automatic clear_reqs();
        req_enable = '0;
        req_addr   = '0;
        req_data   = '0;
        req_float  = '0;
    endtask

    task automatic expect_wb(input logic [4:0] a, input logic [31:0] d, input logic f);
        wb_req_t e;
        e.addr  = a;
        e.data  = d;
        e.float = f;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (reset && wb_enable) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got addr=%0d data=%08h float=%0b, want no write-back",
                         wb_addr, wb_data, wb_float);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                if (wb_addr !== e.addr || wb_data !== e.data || wb_float !== e.float) begin
                    n_err++;
                    $display("FAIL wb_value: got addr=%0d data=%08h float=%0b, want addr=%0d data=%08h float=%0b",
                             wb_addr, wb_data, wb_float, e.addr, e.data, e.float);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rounds;
        // reset values while reset is held
        tick(2);
        check("rst_wb_enable", wb_enable, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_float", wb_float, 0);
        check("rst_stall", stall, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b1;
        tick(1);

        // single uncontended request: visible one cycle later
        set_req(SRC_ALU, 5'd5, 32'h0000_002A, 1'b0);
        expect_wb(5'd5, 32'h0000_002A, 1'b0);
        tick(1);
        clear_reqs();
        check("single_stall", stall, 0);
        tick(3);

        // all four at once from reset priority: 0,1,2,3
        do_reset();
        for (int s = 0; s < N_SRC; s++) begin
            set_req(s, 5'(s + 1), 32'h1000 + 32'(s), 1'b0);
            expect_wb(5'(s + 1), 32'h1000 + 32'(s), 1'b0);
        end
        tick(1);
        clear_reqs();
        tick(5);
        // move last_grant to 0, then the same burst drains as 1,2,3,0
        set_req(SRC_MISC, 5'd9, 32'h0000_0099, 1'b0);
        expect_wb(5'd9, 32'h0000_0099, 1'b0);
        tick(1);
        clear_reqs();
        tick(2);
        for (int s = 0; s < N_SRC; s++) set_req(s, 5'(s + 11), 32'h2000 + 32'(s), 1'b0);
        expect_wb(5'd12, 32'h2001, 1'b0);
        expect_wb(5'd13, 32'h2002, 1'b0);
        expect_wb(5'd14, 32'h2003, 1'b0);
        expect_wb(5'd11, 32'h2000, 1'b0);
        tick(1);
        clear_reqs();
        tick(5);

        // sustained traffic honouring stall: one burst every 4 cycles, no loss
        do_reset();
        rounds = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) check("stall_rises", stall, 1);
            if (!stall) begin
                rounds++;
                for (int s = 0; s < N_SRC; s++) begin
                    set_req(s, 5'(s + 1), 32'hA000_0000 + 32'(s * 256 + c), 1'b0);
                    expect_wb(5'(s + 1), 32'hA000_0000 + 32'(s * 256 + c), 1'b0);
                end
            end else begin
                clear_reqs();
            end
            tick(1);
        end
        clear_reqs();
        tick(4);
        check("stall_rounds", rounds, 3);
        check("stall_no_overflow", overflow, 0);

        // ignoring stall: fpu request of the third cycle is dropped
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < N_SRC; s++) begin
                set_req(s, 5'(s + 10), 32'hB000_0000 + 32'(s * 256 + c), 1'b0);
                if (!(c == 2 && s == SRC_FPU))
                    expect_wb(5'(s + 10), 32'hB000_0000 + 32'(s * 256 + c), 1'b0);
            end
            tick(1);
        end
        clear_reqs();
        check("ovf_set", overflow, 1);
        tick(10);
        check("ovf_sticky", overflow, 1);

        // integer r0 filtered, float f0 passes
        set_req(SRC_MEM, 5'd0, 32'hDEAD_BEEF, 1'b0);
        query_addr = 5'd0;
        query_float = 1'b0;
        #1;
        check("r0_query", query_hit, 0);
        tick(1);
        clear_reqs();
        tick(2);
        set_req(SRC_MEM, 5'd0, 32'h0000_F00D, 1'b1);
        expect_wb(5'd0, 32'h0000_F00D, 1'b1);
        query_float = 1'b1;
        #1;
        check("f0_query", query_hit, 1);
        tick(1);
        clear_reqs();
        tick(2);

        // float r7 queued behind three grants: hit through its wb cycle
        do_reset();
        set_req(SRC_MISC, 5'd1, 32'h0000_0001, 1'b0);
        set_req(SRC_ALU,  5'd2, 32'h0000_0002, 1'b0);
        set_req(SRC_MEM,  5'd3, 32'h0000_0003, 1'b0);
        set_req(SRC_FPU,  5'd7, 32'h0000_7777, 1'b1);
        expect_wb(5'd1, 32'h0000_0001, 1'b0);
        expect_wb(5'd2, 32'h0000_0002, 1'b0);
        expect_wb(5'd3, 32'h0000_0003, 1'b0);
        expect_wb(5'd7, 32'h0000_7777, 1'b1);
        query_addr = 5'd7;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) clear_reqs();
            query_float = 1'b1;
            #1;
            check($sformatf("qhit_f7_c%0d", k), query_hit, (k <= 4) ? 1 : 0);
            query_float = 1'b0;
            #1;
            check($sformatf("qhit_r7_c%0d", k), query_hit, 0);
            tick(1);
        end

        // asynchronous reset with three results queued
        do_reset();
        for (int s = 0; s < N_SRC; s++) set_req(s, 5'(s + 21), 32'hC000 + 32'(s), 1'b0);
        expect_wb(5'd21, 32'hC000, 1'b0);
        tick(1);
        clear_reqs();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_wb_enable", wb_enable, 0);
        check("arst_wb_addr", wb_addr, 0);
        check("arst_wb_data", wb_data, 0);
        check("arst_stall", stall, 0);
        query_addr = 5'd22;
        query_float = 1'b0;
        #1;
        check("arst_query", query_hit, 0);
        tick(2);
        reset = 1'b1;
        tick(6);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
